// File: rtl/os_array_ctrl.sv
// os_array_ctrl: sequencer for an NxN output-stationary systolic array (feed, flush, drain, clear)
module os_array_ctrl #(
  parameter int N       = 4,
  parameter int K_MAX   = 64,
  parameter int MUL_LAT = 1,
  parameter int KW      = $clog2(K_MAX+1),
  parameter int CW      = $clog2(K_MAX+3*N+MUL_LAT+2)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [KW-1:0]        k_len,
  output logic                 busy,
  output logic                 done,
  output logic                 compute_en,
  output logic [CW-1:0]        feed_cnt,
  output logic [N-1:0]         a_feed_en,
  output logic [N-1:0]         b_feed_en,
  output logic                 out_valid,
  output logic [$clog2(N)-1:0] out_row,
  input  logic                 out_ready
);
  localparam int RW = $clog2(N);
  typedef enum logic [2:0] {IDLE, FEED, FLUSH, DRAIN, CLEAR} state_t;
  state_t          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [CW-1:0]   cnt_d, fl_q, fl_d;
  logic [RW-1:0]   row_d;
  logic [N-1:0]    en_d;
  // next-state, captured length, feed index, flush countdown and readout row
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = '0;
    fl_d    = fl_q;
    row_d   = out_row;
    case (state_q)
      IDLE:  if (start && k_len != '0 && k_len <= KW'(K_MAX)) begin
               state_d = FEED;
               k_d     = k_len;
             end
      FEED:  if (feed_cnt == CW'(k_q) + CW'(N-2)) begin
               state_d = FLUSH;
               fl_d    = CW'(N-1+MUL_LAT);
             end else cnt_d = feed_cnt + CW'(1);
      FLUSH: if (fl_q == '0) begin
               state_d = DRAIN;
               row_d   = '0;
             end else fl_d = fl_q - CW'(1);
      DRAIN: if (out_ready) begin
               if (out_row == RW'(N-1)) state_d = CLEAR;
               else row_d = out_row + RW'(1);
             end
      CLEAR: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // lane i is active while its skewed window i..i+k_len-1 covers the next feed index
  always_comb begin
    en_d = '0;
    for (int i = 0; i < N; i++)
      en_d[i] = (state_d == FEED) && (cnt_d >= CW'(i)) && (cnt_d < CW'(i) + CW'(k_d));
  end
  // every output is a register loaded from the next-state decode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      k_q        <= '0;
      fl_q       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      compute_en <= 1'b0;
      feed_cnt   <= '0;
      a_feed_en  <= '0;
      b_feed_en  <= '0;
      out_valid  <= 1'b0;
      out_row    <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      fl_q       <= fl_d;
      busy       <= state_d != IDLE;
      done       <= state_d == CLEAR;
      compute_en <= state_d == FEED || state_d == FLUSH || state_d == DRAIN;
      feed_cnt   <= cnt_d;
      a_feed_en  <= en_d;
      b_feed_en  <= en_d;
      out_valid  <= state_d == DRAIN;
      out_row    <= row_d;
    end
  end
endmodule

// File: tb/tb_os_array_ctrl.sv
// tb_os_array_ctrl: randomized and directed checks of os_array_ctrl against a phase-arithmetic model
module tb_os_array_ctrl;
  localparam int N = 4, K_MAX = 64, ML = 1;
  localparam int KW = $clog2(K_MAX+1), CW = $clog2(K_MAX+3*N+ML+2), RW = $clog2(N);
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, out_ready = 1'b0;
  logic [KW-1:0] k_len = '0;
  logic busy, done, compute_en, out_valid;
  logic [CW-1:0] feed_cnt;
  logic [N-1:0] a_feed_en, b_feed_en;
  logic [RW-1:0] out_row;
  int nvec = 0, errs = 0;
  int m_act = 0, m_clr = 0, m_s = 0, m_k = 0, m_beats = 0;
  int lat, maxcnt, a3_at_max;
  logic [N-1:0] seq [$];

  os_array_ctrl #(.N(N), .K_MAX(K_MAX), .MUL_LAT(ML)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .busy(busy), .done(done),
    .compute_en(compute_en), .feed_cnt(feed_cnt), .a_feed_en(a_feed_en), .b_feed_en(b_feed_en),
    .out_valid(out_valid), .out_row(out_row), .out_ready(out_ready));

  always #5 clk = ~clk;

  // 0 idle, 1 feed, 2 flush, 3 drain, 4 clear -- derived from elapsed tile cycles
  function automatic int ph();
    if (m_act == 0) return 0;
    if (m_clr != 0) return 4;
    if (m_s < m_k + N - 1) return 1;
    if (m_s < m_k + N - 1 + N + ML) return 2;
    return 3;
  endfunction

  function automatic logic [N-1:0] exp_en();
    logic [N-1:0] e = '0;
    for (int i = 0; i < N; i++) e[i] = (ph() == 1) && (i <= m_s) && (m_s < i + m_k);
    return e;
  endfunction

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check();
    int p = ph();
    cmp("busy", busy, 32'(m_act != 0));
    cmp("done", done, 32'(p == 4));
    cmp("compute_en", compute_en, 32'(p >= 1 && p <= 3));
    cmp("feed_cnt", feed_cnt, (p == 1) ? m_s : 0);
    cmp("a_feed_en", a_feed_en, exp_en());
    cmp("b_feed_en", b_feed_en, exp_en());
    cmp("out_valid", out_valid, 32'(p == 3));
    if (p == 3) cmp("out_row", out_row, m_beats);
  endtask

  task automatic model_step(input logic st, input logic [KW-1:0] k, input logic rdy);
    case (ph())
      0: if (st && k >= 1 && k <= K_MAX) begin m_act = 1; m_s = 0; m_beats = 0; m_k = k; end
      4: begin m_act = 0; m_clr = 0; end
      3: if (rdy) begin m_beats++; if (m_beats == N) m_clr = 1; end
      default: m_s++;
    endcase
  endtask

  task automatic cyc(input logic st, input logic [KW-1:0] k, input logic rdy);
    check();
    start = st; k_len = k; out_ready = rdy;
    model_step(st, k, rdy);
    @(posedge clk); #1;
  endtask

  // mode 0: ready held 1; 1: ready 1,0,0 repeating; 2: random ready and stray starts
  task automatic run_tile(input int k, input int mode);
    int n = 1, guard = 0;
    lat = 0; maxcnt = 0; a3_at_max = 0; seq = {};
    cyc(1'b1, KW'(k), 1'b1);
    while (m_act != 0 && guard < 500) begin
      n++; guard++;
      if (done) lat = n;
      if (ph() == 1) seq.push_back(a_feed_en);
      if (busy && 32'(feed_cnt) > maxcnt) begin maxcnt = feed_cnt; a3_at_max = a_feed_en[3]; end
      if (mode == 2) cyc(1'($urandom), KW'($urandom_range(0, 70)), 1'($urandom));
      else cyc(1'b0, '0, (mode == 0) ? 1'b1 : 1'(n % 3 == 0));
    end
    cmp("tile_timeout", 32'(guard < 500), 1);
  endtask

  task automatic async_rst();
    #2 rst = 1'b1;
    #1;
    cmp("rst_busy", busy, 0);
    cmp("rst_done", done, 0);
    cmp("rst_ce", compute_en, 0);
    cmp("rst_cnt", feed_cnt, 0);
    cmp("rst_a", a_feed_en, 0);
    cmp("rst_b", b_feed_en, 0);
    cmp("rst_valid", out_valid, 0);
    cmp("rst_row", out_row, 0);
    #1 rst = 1'b0; start = 1'b0;
    m_act = 0; m_clr = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    #12;
    check();
    rst = 1'b0;
    @(posedge clk); #1;
    // baseline tile k=3
    run_tile(3, 0);
    cmp("latency_k3", lat, 17);
    cmp("feed_len_k3", seq.size(), 6);
    if (seq.size() == 6) begin
      cmp("seq0", seq[0], 4'b0001); cmp("seq1", seq[1], 4'b0011);
      cmp("seq2", seq[2], 4'b0111); cmp("seq3", seq[3], 4'b1110);
      cmp("seq4", seq[4], 4'b1100); cmp("seq5", seq[5], 4'b1000);
    end
    // back-to-back tile with identity-sized k
    run_tile(4, 0);
    cmp("latency_k4", lat, 18);
    // illegal lengths ignored
    cyc(1'b1, KW'(0), 1'b1);
    cyc(1'b1, KW'(K_MAX+1), 1'b1);
    cyc(1'b0, '0, 1'b1);
    // stalled drain
    run_tile(2, 1);
    // maximum length
    run_tile(K_MAX, 0);
    cmp("maxcnt", maxcnt, K_MAX + N - 2);
    cmp("a3_at_max", a3_at_max, 1);
    cmp("latency_kmax", lat, 1 + (K_MAX + N - 1) + (N + ML) + N + 1);
    // reset mid-FLUSH
    cyc(1'b1, KW'(5), 1'b1);
    for (int g = 0; g < 50 && ph() != 2; g++) cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b1);
    async_rst();
    cyc(1'b0, '0, 1'b1);
    // reset mid-DRAIN while stalled
    cyc(1'b1, KW'(6), 1'b0);
    for (int g = 0; g < 50 && ph() != 3; g++) cyc(1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b0);
    async_rst();
    run_tile(2, 0);
    cmp("latency_after_rst", lat, 1 + (2 + N - 1) + (N + ML) + N + 1);
    // randomized tiles with stray starts and random backpressure
    for (int t = 0; t < 25; t++) run_tile($urandom_range(0, 70), 2);
    for (int t = 0; t < 5; t++) cyc(1'($urandom), KW'($urandom_range(65, 127)), 1'($urandom));
    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end
endmodule

// File: doc/os_array_ctrl.md
Name: os_array_ctrl

Overview:
Sequencer for an NxN output-stationary systolic array built from signed 8x8 MAC PEs, whose accumulators clear whenever compute_en is low. On start it drives skewed operand-feed enables to the row (A) and column (B) edge feeders, waits for the skew and multiplier pipeline to flush, and drains the N result rows over a valid/ready handshake. It then drops compute_en for one cycle to clear the array. It sits between the top-level command interface and the PE array plus its edge buffers.

Parameters:
N, 4, array dimension (rows = columns = N), N >= 2
K_MAX, 64, maximum reduction length per tile
MUL_LAT, 1, pipeline latency of the PE multiplier in cycles, >= 0
KW, $clog2(K_MAX+1), width of k_len
CW, $clog2(K_MAX+3*N+MUL_LAT+2), width of internal and exported counter

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
start  in  1  tile request, sampled in IDLE only
k_len  in  KW  reduction length, captured on accepted start
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse in CLEAR
compute_en  out  1  broadcast to all PEs
feed_cnt  out  CW  FEED-phase cycle index; lane i reads buffer address feed_cnt-i
a_feed_en  out  N  bit i: row-i feeder drives data (else drives 0)
b_feed_en  out  N  bit j: column-j feeder drives data (else drives 0)
out_valid  out  1  result row available on the array readout mux
out_row  out  $clog2(N)  row index selected for readout
out_ready  in  1  downstream accepts the current row

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, compute_en=0, feed_cnt=0, a_feed_en=0, b_feed_en=0, out_valid=0, out_row=0; captured k_len=0. Reset mid-tile abandons the tile; no done.
- States: IDLE, FEED, FLUSH, DRAIN, CLEAR. All outputs are registered.
- IDLE: compute_en=0. start=1 with k_len in 1..K_MAX -> capture k_len, feed_cnt=0, go to FEED. start with k_len=0 or k_len>K_MAX is ignored; stay in IDLE with no done. start outside IDLE is ignored.
- FEED: compute_en=1. Lasts exactly k_len+N-1 cycles, feed_cnt=0..k_len+N-2. In the cycle where feed_cnt=c: a_feed_en[i]=1 iff i <= c < i+k_len, and b_feed_en[j] uses the same rule. After the last FEED cycle go to FLUSH.
- FLUSH: compute_en=1, all feed enables 0. Lasts exactly (N-1)+MUL_LAT+1 cycles, so the last product reaches PE(N-1,N-1) and is accumulated. Then go to DRAIN with out_row=0.
- DRAIN: compute_en stays 1 so the accumulators hold; inputs are zero, so products are 0. out_valid=1. A beat completes when out_valid and out_ready are both high; out_row then increments. out_ready low stalls indefinitely. The beat with out_row=N-1 goes to CLEAR with out_valid=0 in the next cycle. out_row and out_valid must not change while stalled.
- CLEAR: exactly one cycle: compute_en=0 (PEs zero their accumulators and pipeline), done=1, busy=1. Next cycle: IDLE with busy=0. A start during CLEAR is ignored. A start in the first IDLE cycle is accepted.
- Counters never wrap: feed_cnt max is K_MAX+N-2, held in CW bits. The FLUSH counter is a separate count-down.
- Tile latency, start to done, with out_ready held 1: 1 + (k_len+N-1) + (N+MUL_LAT) + N + 1 cycles.

Test Plan:
- N=4, MUL_LAT=1, k_len=3, out_ready=1 -> FEED 6 cycles; a_feed_en per cycle = 0001,0011,0111,1110,1100,1000; FLUSH 5 cycles; out_row 0,1,2,3 on consecutive cycles; done 1 cycle later; compute_en low only in CLEAR and IDLE; start to done = 17 cycles.
- Same tile run against a 4x4 array of real PEs with A = B = identity (k_len=4) -> drained rows equal identity (16-bit 1 on the diagonal, 0 elsewhere). A second tile immediately after shows no residue from the first.
- out_ready toggling 1,0,0,1,... during DRAIN -> out_row advances only on handshake cycles, out_valid stays 1, exactly 4 beats, then done.
- start with k_len=0, start with k_len=K_MAX+1, and start asserted during FEED -> ignored: no state change, no done.
- k_len=K_MAX=64 -> feed_cnt reaches 66 without overflow; last a_feed_en[3] high at feed_cnt=66; tile completes normally.
- rst pulsed mid-FLUSH and mid-DRAIN -> all outputs go to 0 asynchronously, no done; a new start afterwards runs a clean tile.
